// File: rtl/adder8_recover.sv
// adder8_recover
//   Recovers addend a from a partitioned-adder result: a = {carry, sum} - b.
//   The subtraction runs in two slices (low SLICE_LO bits, then the high
//   9-SLICE_LO bits including the carry bit) with a borrow chained between
//   them, matching the adder's partition boundary.
//
// Parameters
//   SLICE_LO  width of the low slice, legal range 1..7 (default 5)
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     request valid            in_ready   block idle, can accept
//   sum          sum word (8b)            cout_n     carry-out, active-low
//   addend_b     known addend b (8b)
//   out_valid    result valid             out_ready  consumer accepts result
//   addend_a     recovered addend (8b)    range_err  recovered value outside 0..255
//   err_cnt      retired transactions with range_err set (16b)
//
// Configuration
//   ADDER8_RECOVER_ERRCNT_EN  defined: err_cnt is a saturating counter.
//                             undefined: err_cnt is tied to zero.
module adder8_recover #(
  parameter int unsigned SLICE_LO = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  sum,
  input  logic        cout_n,
  input  logic [7:0]  addend_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  addend_a,
  output logic        range_err,
  output logic [15:0] err_cnt
);

  localparam int unsigned HI_W = 9 - SLICE_LO;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  state_e                state_q, state_d;
  logic [7:0]            sum_q, sum_d;
  logic                  cout_n_q, cout_n_d;
  logic [7:0]            b_q, b_d;
  logic [SLICE_LO-1:0]   diff_lo_q, diff_lo_d;
  logic                  borrow_lo_q, borrow_lo_d;
  logic [HI_W-1:0]       diff_hi_q, diff_hi_d;
  logic                  borrow_hi_q, borrow_hi_d;
  logic [7:0]            addend_a_q, addend_a_d;
  logic                  range_err_q, range_err_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;

  logic [8:0]            t_op;
  logic [SLICE_LO:0]     lo_full;
  logic [HI_W:0]         hi_full;
  logic [8:0]            result9;
  logic                  retire;

  // Slice arithmetic: the extra top bit of each difference is the borrow out.
  always_comb begin
    t_op    = {~cout_n_q, sum_q};
    lo_full = {1'b0, t_op[SLICE_LO-1:0]} - {1'b0, b_q[SLICE_LO-1:0]};
    hi_full = {1'b0, t_op[8:SLICE_LO]} - {2'b00, b_q[7:SLICE_LO]}
            - {{HI_W{1'b0}}, borrow_lo_q};
    result9 = {diff_hi_q, diff_lo_q};
  end

  assign retire = (state_q == DONE) && out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    cout_n_d    = cout_n_q;
    b_d         = b_q;
    diff_lo_d   = diff_lo_q;
    borrow_lo_d = borrow_lo_q;
    diff_hi_d   = diff_hi_q;
    borrow_hi_d = borrow_hi_q;
    addend_a_d  = addend_a_q;
    range_err_d = range_err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sum_d      = sum;
          cout_n_d   = cout_n;
          b_d        = addend_b;
          in_ready_d = 1'b0;
          state_d    = LO;
        end
      end
      LO: begin
        diff_lo_d   = lo_full[SLICE_LO-1:0];
        borrow_lo_d = lo_full[SLICE_LO];
        state_d     = HI;
      end
      HI: begin
        diff_hi_d   = hi_full[HI_W-1:0];
        borrow_hi_d = hi_full[HI_W];
        state_d     = DONE;
      end
      DONE: begin
        // First DONE cycle loads the output registers; out_valid rises on
        // that edge so addend_a/range_err are already stable when seen valid.
        if (!out_valid_q) begin
          addend_a_d  = result9[7:0];
          range_err_d = borrow_hi_q | diff_hi_q[HI_W-1];
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      cout_n_q    <= 1'b1;
      b_q         <= '0;
      diff_lo_q   <= '0;
      borrow_lo_q <= 1'b0;
      diff_hi_q   <= '0;
      borrow_hi_q <= 1'b0;
      addend_a_q  <= '0;
      range_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cout_n_q    <= cout_n_d;
      b_q         <= b_d;
      diff_lo_q   <= diff_lo_d;
      borrow_lo_q <= borrow_lo_d;
      diff_hi_q   <= diff_hi_d;
      borrow_hi_q <= borrow_hi_d;
      addend_a_q  <= addend_a_d;
      range_err_q <= range_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef ADDER8_RECOVER_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (retire && range_err_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign err_cnt       = '0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign addend_a  = addend_a_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_adder8_recover.sv
// Bench for adder8_recover: three instances (SLICE_LO = 5, 1, 7) share the
// same stimulus; expected results are queued at accept and compared at retire.
module tb_adder8_recover;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        cout_n = 1'b1;
  logic        out_ready = 1'b1;
  logic [7:0]  sum = '0;
  logic [7:0]  addend_b = '0;

  logic        in_ready  [3];
  logic        out_valid [3];
  logic        range_err [3];
  logic [7:0]  addend_a  [3];
  logic [15:0] err_cnt   [3];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [8:0]  exp_q [$];
  logic [15:0] err_model = '0;

  always #5 clk = ~clk;

  adder8_recover u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .sum(sum), .cout_n(cout_n), .addend_b(addend_b), .out_valid(out_valid[0]),
    .out_ready(out_ready), .addend_a(addend_a[0]), .range_err(range_err[0]),
    .err_cnt(err_cnt[0])
  );

  adder8_recover #(.SLICE_LO(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .sum(sum), .cout_n(cout_n), .addend_b(addend_b), .out_valid(out_valid[1]),
    .out_ready(out_ready), .addend_a(addend_a[1]), .range_err(range_err[1]),
    .err_cnt(err_cnt[1])
  );

  adder8_recover #(.SLICE_LO(7)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .sum(sum), .cout_n(cout_n), .addend_b(addend_b), .out_valid(out_valid[2]),
    .out_ready(out_ready), .addend_a(addend_a[2]), .range_err(range_err[2]),
    .err_cnt(err_cnt[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: D = {~cout_n, sum} - b as a signed integer.
  function automatic logic [8:0] ref_model(input logic [7:0] s, input logic cn,
                                           input logic [7:0] b);
    int t;
    int d;
    t = int'({~cn, s});
    d = t - int'(b);
    return {(d < 0) || (d > 255), d[7:0]};
  endfunction

  function automatic logic [15:0] exp_err();
`ifdef ADDER8_RECOVER_ERRCNT_EN
    return err_model;
`else
    return 16'h0000;
`endif
  endfunction

  // Scoreboard: the negedge before a retiring edge compares all instances.
  always @(negedge clk) begin
    if (rst_n && out_valid[0] && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'd1);
          chk($sformatf("addend_a[%0d]", i), 32'(addend_a[i]), 32'(e[7:0]));
          chk($sformatf("range_err[%0d]", i), 32'(range_err[i]), 32'(e[8]));
        end
        if (e[8] && err_model != 16'hFFFF) err_model = err_model + 16'd1;
      end
    end
  end

  // Issue one request and wait until out_valid is seen.
  task automatic run_txn(input logic [7:0] s, input logic cn, input logic [7:0] b,
                         input bit check_lat);
    int n;
    n = 0;
    while (!in_ready[0] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    sum = s; cout_n = cn; addend_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(ref_model(s, cn, b));
    if (check_lat) chk("in_ready_busy", 32'(in_ready[0]), 32'd0);
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (check_lat) chk("latency", 32'(n), 32'd3);
    else if (n >= 20) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic retire_txn();
    @(posedge clk); #1;
    chk("out_valid_after_retire", 32'(out_valid[0]), 32'd0);
    chk("err_cnt", 32'(err_cnt[0]), 32'(exp_err()));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] snap_a;
    logic       snap_r;

    // Reset values
    #12;
    chk("rst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_addend_a", 32'(addend_a[0]), 32'h00);
    chk("rst_range_err", 32'(range_err[0]), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt[0]), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_txn(8'h2C, 1'b1, 8'h1A, 1'b1); retire_txn();
    run_txn(8'h10, 1'b0, 8'hF0, 1'b1); retire_txn();
    run_txn(8'h05, 1'b1, 8'h06, 1'b1); retire_txn();
    run_txn(8'h00, 1'b0, 8'h00, 1'b1); retire_txn();
    run_txn(8'hFF, 1'b0, 8'h00, 1'b1); retire_txn();
    run_txn(8'h00, 1'b1, 8'hFF, 1'b1); retire_txn();
    run_txn(8'hFF, 1'b1, 8'hFF, 1'b1); retire_txn();

    // Backpressure with input churn in DONE
    out_ready = 1'b0;
    run_txn(8'h77, 1'b1, 8'h33, 1'b1);
    snap_a = addend_a[0];
    snap_r = range_err[0];
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); sum = 8'($urandom); addend_b = 8'($urandom);
      cout_n = 1'($urandom);
      chk("bp_addend_a", 32'(addend_a[0]), 32'(snap_a));
      chk("bp_range_err", 32'(range_err[0]), 32'(snap_r));
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", 32'(in_ready[0]), 32'd1);
    chk("bp_out_valid_after", 32'(out_valid[0]), 32'd0);
    chk("bp_err_cnt", 32'(err_cnt[0]), 32'(exp_err()));
    repeat (4) @(posedge clk);
    #1;
    chk("bp_no_second_txn", 32'(out_valid[0]), 32'd0);

    // Reset while in HI
    sum = 8'h05; cout_n = 1'b1; addend_b = 8'h06; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    err_model = '0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mid_rst_out_valid[%0d]", i), 32'(out_valid[i]), 32'd0);
      chk($sformatf("mid_rst_addend_a[%0d]", i), 32'(addend_a[i]), 32'h00);
      chk($sformatf("mid_rst_in_ready[%0d]", i), 32'(in_ready[i]), 32'd1);
      chk($sformatf("mid_rst_err_cnt[%0d]", i), 32'(err_cnt[i]), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_result", 32'(out_valid[0]), 32'd0);
    end

    // Random sweep across all three slice widths
    for (int i = 0; i < 1000; i++) begin
      run_txn(8'($urandom), 1'($urandom), 8'($urandom), 1'b0);
      retire_txn();
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("final_err_cnt[%0d]", i), 32'(err_cnt[i]), 32'(exp_err()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
